barrel_sched: RTL

Parametrised barrel launch scheduler for the game-logic layer. It supersedes the fixed 5-slot controller with these features:
- N independent barrel slots, allocated lowest-free-first.
- Edge-detected launches and a configurable post-launch cooldown.
- An optional auto-launch mode driven by an internal period timer.

It sits between the keyboard/control decoder and the per-barrel movement/draw modules. `active` enables each barrel's drawing, and `done` from each barrel frees its slot.

---
 rtl/barrel_pkg.sv | 21 ++
 rtl/barrel_sched_slot_alloc.sv | 29 ++
 rtl/barrel_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/barrel_pkg.sv
// Shared types and helpers for the barrel launch scheduler.
package barrel_pkg;

   // Scheduler control state: waiting for a request, or holding off after a launch.
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_COOLDOWN = 1'b1
   } barrel_state_t;

   // Upper bound on the number of barrel slots a scheduler instance may manage.
   localparam int MAX_SLOTS = 16;

   // Width of a slot index: $clog2(n), but at least one bit so a single slot still
   // gets a usable index port.
   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : barrel_pkg

// File: rtl/barrel_sched_slot_alloc.sv
// Lowest-free-first slot allocator: a purely combinational priority encoder
// that finds the lowest-numbered zero in the busy vector.
module slot_alloc
   import barrel_pkg::*;
#(
   parameter int SLOTS = 8
) (
   input  logic [SLOTS-1:0]          busy,
   output logic [idx_w(SLOTS)-1:0]   idx,
   output logic                      any_free
);

   localparam int IW = idx_w(SLOTS);

   // Scan from the top down so the lowest free slot is the last one to win.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path through
      // this block leaves a value unassigned, which would infer a latch.
      idx      = '0;
      any_free = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            idx      = IW'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule : slot_alloc

// File: rtl/barrel_sched.sv
// Barrel launch scheduler: allocates barrel slots lowest-free-first on each
// accepted launch request (key edge or auto-mode timer), enforces a post-launch
// cooldown, and frees slots on the rising edge of each slot's done level.
module barrel_sched
   import barrel_pkg::*;
#(
   parameter int SLOTS       = 8,
   parameter int DELAY_TIME  = 162_500_000,
   parameter int AUTO_PERIOD = 325_000_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      game_en,
   input  logic                      animation,
   input  logic                      auto_mode,
   input  logic                      key,
   input  logic [SLOTS-1:0]          done,
   output logic [SLOTS-1:0]          active,
   output logic                      launch,
   output logic [idx_w(SLOTS)-1:0]   launch_idx,
   output logic                      full,
   output logic                      cooling
);

   localparam int IW = idx_w(SLOTS);
   // Counters are sized to hold their terminal value without wrapping.
   localparam int DW = $clog2(DELAY_TIME + 1);
   localparam int AW = $clog2(AUTO_PERIOD + 1);

   localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_TIME - 1);
   localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_PERIOD - 1);

   // Registered state
   barrel_state_t    state_q,      state_d;
   logic             key_q;
   logic [SLOTS-1:0] done_q;
   logic [SLOTS-1:0] active_q,     active_d;
   logic             launch_q,     launch_d;
   logic [IW-1:0]    launch_idx_q, launch_idx_d;
   logic [DW-1:0]    delay_cnt_q,  delay_cnt_d;
   logic [AW-1:0]    auto_cnt_q,   auto_cnt_d;

   // Combinational helpers
   logic             key_req;
   logic [SLOTS-1:0] done_ev;
   logic             auto_run;
   logic             auto_exp;
   logic             request;
   logic             accept;
   logic [IW-1:0]    free_idx;
   logic             any_free;

   // Lowest free slot, taken from the registered active vector so a slot freed
   // in this cycle only becomes eligible from the next cycle on.
   slot_alloc #(
      .SLOTS (SLOTS)
   ) u_alloc (
      .busy     (active_q),
      .idx      (free_idx),
      .any_free (any_free)
   );

   // Edge detection and launch request qualification.
   always_comb begin
      key_req  = key & ~key_q;
      done_ev  = done & ~done_q;
      auto_run = (state_q == ST_IDLE) && auto_mode && game_en && !animation;
      auto_exp = auto_run && (auto_cnt_q == AUTO_LAST);
      request  = auto_mode ? auto_exp : key_req;
      accept   = (state_q == ST_IDLE) && request && game_en && !animation && any_free;
   end

   // Next-state logic for slots, outputs, FSM and both counters.
   always_comb begin
      state_d      = state_q;
      active_d     = active_q & ~done_ev;
      launch_d     = 1'b0;
      launch_idx_d = launch_idx_q;
      delay_cnt_d  = delay_cnt_q;
      auto_cnt_d   = '0;

      // The auto timer only runs while idle and unblocked; expiry restarts it.
      if (auto_run && !auto_exp) begin
         auto_cnt_d = auto_cnt_q + AW'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               active_d[free_idx] = 1'b1;
               launch_d           = 1'b1;
               launch_idx_d       = free_idx;
               delay_cnt_d        = '0;
               state_d            = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (delay_cnt_q == DELAY_LAST) begin
               delay_cnt_d = '0;
               state_d     = ST_IDLE;
            end else begin
               delay_cnt_d = delay_cnt_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Leaving the game flushes every slot and returns to idle; the last
      // launch index is held as an informational value.
      if (!game_en) begin
         state_d     = ST_IDLE;
         active_d    = '0;
         launch_d    = 1'b0;
         delay_cnt_d = '0;
         auto_cnt_d  = '0;
      end
   end

   // Input edge-detect samplers; they track their inputs even while game_en is low.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from pre-edge values, independent of statement order.
      if (!rst_n) begin
         key_q  <= 1'b0;
         done_q <= '0;
      end else begin
         key_q  <= key;
         done_q <= done;
      end
   end

   // Scheduler state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         active_q     <= '0;
         launch_q     <= 1'b0;
         launch_idx_q <= '0;
         delay_cnt_q  <= '0;
         auto_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         launch_q     <= launch_d;
         launch_idx_q <= launch_idx_d;
         delay_cnt_q  <= delay_cnt_d;
         auto_cnt_q   <= auto_cnt_d;
      end
   end

   assign active     = active_q;
   assign launch     = launch_q;
   assign launch_idx = launch_idx_q;
   assign full       = &active_q;
   assign cooling    = (state_q == ST_COOLDOWN);

endmodule : barrel_sched
